mul_issue_ctrl: RTL and testbench

- EX-stage issue/sequencing controller sitting directly upstream of the 3-cycle pipelined `multiplier` block.
- Accepts an M-extension multiply from the ID/EX register and latches its operands, funct3 and rd.
- Issues a single-cycle `start` pulse to the multiplier, holds the operands stable, and stalls the front of the pipeline for the full latency.
- Captures the product and hands it to the EX/MEM register with a one-cycle `done` strobe.

---
 rtl/mul_issue_ctrl.sv | 112 +++++++++++
 tb/tb_mul_issue_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// EX-stage issue controller for the pipelined multiplier: latches one multiply,
// pulses start, stalls the front end for the latency, then presents the product.
module mul_issue_ctrl #(
   parameter int LATENCY = 3,
   parameter int RD_W    = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ex_valid,
   input  logic            ex_is_mul,
   input  logic [2:0]      ex_funct3,
   input  logic [31:0]     ex_rs1_val,
   input  logic [31:0]     ex_rs2_val,
   input  logic [RD_W-1:0] ex_rd,
   input  logic            flush,
   output logic            mul_start,
   output logic [2:0]      mul_funct3,
   output logic [31:0]     mul_a,
   output logic [31:0]     mul_b,
   input  logic [31:0]     mul_result,
   output logic            stall,
   output logic            done,
   output logic [31:0]     result,
   output logic [RD_W-1:0] rd
);

   localparam int CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              start_q, start_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [31:0]       a_q, a_d, b_q, b_d;
   logic [31:0]       result_q, result_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic              accept;

   assign accept = (state_q == IDLE) && ex_valid && ex_is_mul && !flush;

   // Held in EX from the accept cycle until the product is captured.
   assign stall      = !flush && (accept || state_q == BUSY);
   assign done       = (state_q == DONE) && !flush;
   assign mul_start  = start_q;
   assign mul_funct3 = funct3_q;
   assign mul_a      = a_q;
   assign mul_b      = b_q;
   assign result     = result_q;
   assign rd         = rd_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      start_d  = 1'b0;
      funct3_d = funct3_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      rd_d     = rd_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d      = ex_rs1_val;
               b_d      = ex_rs2_val;
               funct3_d = ex_funct3;
               rd_d     = ex_rd;
               start_d  = 1'b1;
               cnt_d    = CNT_W'(LATENCY - 1);
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               result_d = mul_result;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         start_q  <= 1'b0;
         funct3_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         start_q  <= start_d;
         funct3_q <= funct3_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a 3-stage multiplier model that only
// shows a valid product in the cycle the controller is meant to capture it.
module tb_mul_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_is_mul, flush;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_rs1_val, ex_rs2_val;
   logic [4:0]  ex_rd;
   logic        mul_start, stall, done;
   logic [2:0]  mul_funct3;
   logic [31:0] mul_a, mul_b, mul_result, result;
   logic [4:0]  rd;

   int total = 0;
   int bad   = 0;
   int starts = 0;
   int dones  = 0;
   int s0, d0;

   always #5 clk = ~clk;

   mul_issue_ctrl #(.LATENCY(3), .RD_W(5)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_mul(ex_is_mul),
      .ex_funct3(ex_funct3), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
      .ex_rd(ex_rd), .flush(flush), .mul_start(mul_start), .mul_funct3(mul_funct3),
      .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .stall(stall),
      .done(done), .result(result), .rd(rd)
   );

   // Multiplier model: product appears two cycles after the start cycle.
   logic [31:0] p1, p2;
   logic        v1, v2;
   function automatic logic [31:0] mul_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] wide;
      wide = {32'b0, a} * {32'b0, b};
      return (f3 == 3'b011) ? wide[63:32] : wide[31:0];
   endfunction

   always @(posedge clk) begin
      p1 <= mul_f(mul_funct3, mul_a, mul_b);
      v1 <= mul_start;
      p2 <= p1;
      v2 <= v1;
      if (mul_start) starts <= starts + 1;
      if (done)      dones  <= dones + 1;
   end
   assign mul_result = v2 ? p2 : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic m, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
      ex_valid = v; ex_is_mul = m; ex_funct3 = f3;
      ex_rs1_val = a; ex_rs2_val = b; ex_rd = r;
   endtask

   task automatic cyc;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; v1 = 1'b0; v2 = 1'b0; p1 = '0; p2 = '0;
      drv(0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
      cyc; cyc; reset = 1'b0; #1;
      chk("rst_start", {31'b0, mul_start}, 0);
      chk("rst_stall", {31'b0, stall}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_a", mul_a, 0);
      chk("rst_result", result, 0);
      chk("rst_rd", {27'b0, rd}, 0);

      // MUL 7x6 -> 42, rd 5
      cyc; drv(1, 1, 3'b000, 32'd7, 32'd6, 5'd5); #1;
      chk("m1_T0_stall", {31'b0, stall}, 1);
      chk("m1_T0_start", {31'b0, mul_start}, 0);
      cyc; #1;
      chk("m1_T1_start", {31'b0, mul_start}, 1);
      chk("m1_T1_stall", {31'b0, stall}, 1);
      chk("m1_T1_a", mul_a, 7);
      chk("m1_T1_b", mul_b, 6);
      cyc; #1;
      chk("m1_T2_start", {31'b0, mul_start}, 0);
      chk("m1_T2_stall", {31'b0, stall}, 1);
      cyc; #1;
      chk("m1_T3_stall", {31'b0, stall}, 1);
      chk("m1_T3_done", {31'b0, done}, 0);
      cyc; #1;
      chk("m1_T4_done", {31'b0, done}, 1);
      chk("m1_T4_result", result, 42);
      chk("m1_T4_rd", {27'b0, rd}, 5);
      chk("m1_T4_stall", {31'b0, stall}, 0);
      cyc; drv(0, 0, 3'd0, 32'd0, 32'd0, 5'd0); #1;
      chk("m1_T5_done", {31'b0, done}, 0);

      // MULHU all-ones, rs1 changes while busy
      cyc; drv(1, 1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7); #1;
      chk("hu_T0_stall", {31'b0, stall}, 1);
      cyc; #1;
      chk("hu_T1_f3", {29'b0, mul_funct3}, 3);
      cyc; ex_rs1_val = 32'd0; #1;
      chk("hu_T2_a_held", mul_a, 32'hFFFF_FFFF);
      cyc; #1;
      chk("hu_T3_a_held", mul_a, 32'hFFFF_FFFF);
      cyc; #1;
      chk("hu_T4_done", {31'b0, done}, 1);
      chk("hu_T4_result", result, 32'hFFFF_FFFE);
      chk("hu_T4_rd", {27'b0, rd}, 7);
      cyc; drv(0, 0, 3'd0, 32'd0, 32'd0, 5'd0); #1;

      // Back-to-back 3x4 then 5x5
      s0 = starts; d0 = dones;
      cyc; drv(1, 1, 3'b000, 32'd3, 32'd4, 5'd1); #1;        // T0
      cyc; cyc; cyc; cyc; #1;                                // T4
      chk("bb_T4_done", {31'b0, done}, 1);
      chk("bb_T4_result", result, 12);
      chk("bb_T4_rd", {27'b0, rd}, 1);
      cyc; drv(1, 1, 3'b000, 32'd5, 32'd5, 5'd2); #1;        // T5
      chk("bb_T5_stall", {31'b0, stall}, 1);
      chk("bb_T5_start", {31'b0, mul_start}, 0);
      cyc; #1;                                               // T6
      chk("bb_T6_start", {31'b0, mul_start}, 1);
      cyc; cyc; cyc; #1;                                     // T9
      chk("bb_T9_done", {31'b0, done}, 1);
      chk("bb_T9_result", result, 25);
      chk("bb_T9_rd", {27'b0, rd}, 2);
      cyc; drv(0, 0, 3'd0, 32'd0, 32'd0, 5'd0); #1;
      cyc; cyc; #1;
      chk("bb_starts", starts - s0, 2);
      chk("bb_dones", dones - d0, 2);

      // Flush during BUSY
      d0 = dones;
      cyc; drv(1, 1, 3'b000, 32'd9, 32'd9, 5'd3); #1;        // T0
      cyc; #1;                                               // T1
      cyc; flush = 1'b1; #1;                                 // T2
      chk("fl_T2_stall", {31'b0, stall}, 0);
      chk("fl_T2_done", {31'b0, done}, 0);
      cyc; flush = 1'b0; drv(0, 0, 3'd0, 32'd0, 32'd0, 5'd0); #1;  // T3
      chk("fl_T3_stall", {31'b0, stall}, 0);
      chk("fl_T3_start", {31'b0, mul_start}, 0);
      for (int i = 0; i < 5; i++) cyc;
      #1;
      chk("fl_no_done", dones - d0, 0);
      cyc; drv(1, 1, 3'b000, 32'd2, 32'd2, 5'd4); #1;
      chk("fl_re_accept", {31'b0, stall}, 1);
      cyc; cyc; cyc; cyc; #1;
      chk("fl_2x2_done", {31'b0, done}, 1);
      chk("fl_2x2_result", result, 4);
      cyc; drv(0, 0, 3'd0, 32'd0, 32'd0, 5'd0); #1;

      // Synchronous reset mid-operation
      d0 = dones;
      cyc; drv(1, 1, 3'b000, 32'd3, 32'd3, 5'd9); #1;        // T0
      cyc; #1;                                               // T1
      cyc; reset = 1'b1; drv(0, 0, 3'd0, 32'd0, 32'd0, 5'd0); #1;  // T2
      cyc; reset = 1'b0; #1;                                 // T3
      chk("rs_start", {31'b0, mul_start}, 0);
      chk("rs_f3", {29'b0, mul_funct3}, 0);
      chk("rs_a", mul_a, 0);
      chk("rs_b", mul_b, 0);
      chk("rs_result", result, 0);
      chk("rs_rd", {27'b0, rd}, 0);
      chk("rs_stall", {31'b0, stall}, 0);
      chk("rs_done", {31'b0, done}, 0);
      cyc; drv(1, 0, 3'b000, 32'd1, 32'd1, 5'd6); #1;        // ADD
      chk("add_stall", {31'b0, stall}, 0);
      cyc; cyc; #1;
      chk("add_done", {31'b0, done}, 0);
      chk("add_stall2", {31'b0, stall}, 0);
      chk("rs_no_done", dones - d0, 0);

      // Invalid multiply ignored
      s0 = starts;
      for (int i = 0; i < 10; i++) begin
         cyc; drv(0, 1, 3'b000, 32'd8, 32'd8, 5'd8); #1;
         chk("inv_stall", {31'b0, stall}, 0);
      end
      cyc; #1;
      chk("inv_starts", starts - s0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
